// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg : ALU opcode encodings and result-flag bit positions        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] ALU_ADDU  = 4'b0000;
  localparam logic [3:0] ALU_SUBU  = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_NOR   = 4'b0111;
  localparam logic [3:0] ALU_LUI   = 4'b1000;
  localparam logic [3:0] ALU_LUI_X = 4'b1001;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1100;
  localparam logic [3:0] ALU_SRL   = 4'b1101;
  localparam logic [3:0] ALU_SLL   = 4'b1110;
  localparam logic [3:0] ALU_SLL_X = 4'b1111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu : 32-bit combinational ALU with {V,N,C,Z} flags                 |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alu
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_aluc,
  output logic [31:0] o_r,
  output logic [3:0]  o_flags
);

  logic [32:0] w_sum;
  logic [32:0] w_dif;
  logic [31:0] w_r;
  logic        w_c;
  logic        w_v;

  // w_dif[32] is the unsigned borrow, reported as carry for subtraction
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_r = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (i_aluc)
      ALU_ADDU: begin
        w_r = w_sum[31:0];
        w_c = w_sum[32];
      end
      ALU_SUBU: begin
        w_r = w_dif[31:0];
        w_c = w_dif[32];
      end
      ALU_ADD: begin
        w_r = w_sum[31:0];
        w_c = w_sum[32];
        w_v = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
      end
      ALU_SUB: begin
        w_r = w_dif[31:0];
        w_c = w_dif[32];
        w_v = (i_a[31] != i_b[31]) && (w_dif[31] != i_a[31]);
      end
      ALU_AND:             w_r = i_a & i_b;
      ALU_OR:              w_r = i_a | i_b;
      ALU_XOR:             w_r = i_a ^ i_b;
      ALU_NOR:             w_r = ~(i_a | i_b);
      ALU_LUI, ALU_LUI_X:  w_r = {i_b[15:0], 16'h0000};
      ALU_SLTU:            w_r = {31'd0, w_dif[32]};
      ALU_SLT:             w_r = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SRA:             w_r = 32'($signed(i_b) >>> i_a[4:0]);
      ALU_SRL:             w_r = i_b >> i_a[4:0];
      ALU_SLL, ALU_SLL_X:  w_r = i_b << i_a[4:0];
      default:             w_r = '0;
    endcase
  end

  assign o_r             = w_r;
  assign o_flags[FLAG_Z] = (w_r == 32'd0);
  assign o_flags[FLAG_C] = w_c;
  assign o_flags[FLAG_N] = w_r[31];
  assign o_flags[FLAG_V] = w_v;

endmodule : alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_arbiter : round-robin sharing of one ALU with a 1-deep result   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  input  logic [N_REQ*4-1:0]  req_aluc,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_r,
  output logic [3:0]          rsp_flags
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]     r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_r;
  logic [3:0]     r_flags;

  logic           w_any;
  logic [IDW-1:0] w_gnt;
  logic [IDW-1:0] w_cand;
  int             w_idx;
  logic           w_slot_free;
  logic           w_accept;
  logic [IDW-1:0] w_ptr_nxt;
  logic [31:0]    w_a;
  logic [31:0]    w_b;
  logic [3:0]     w_aluc;
  logic [31:0]    w_r;
  logic [3:0]     w_flags;

  // Scan from the farthest offset down so the nearest valid requester wins
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_cand = '0;
    w_idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      w_cand = IDW'(w_idx);
      if (req_valid[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  assign w_slot_free = (r_state == S_EMPTY) || rsp_ready;
  assign w_accept    = rst_n && w_any && w_slot_free;
  assign req_ready   = w_accept ? (N_REQ'(1'b1) << w_gnt) : '0;
  assign w_ptr_nxt   = (w_gnt == IDW'(N_REQ - 1)) ? '0 : w_gnt + IDW'(1);

  assign w_a    = req_a[{w_gnt, 5'b00000} +: 32];
  assign w_b    = req_b[{w_gnt, 5'b00000} +: 32];
  assign w_aluc = req_aluc[{w_gnt, 2'b00} +: 4];

  alu u_alu (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_aluc  (w_aluc),
    .o_r     (w_r),
    .o_flags (w_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) r_state <= S_FULL;
        S_FULL:  if (!w_accept && rsp_ready) r_state <= S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_r      <= '0;
      r_flags  <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_ptr_nxt;
      r_id     <= w_gnt;
      r_r      <= w_r;
      r_flags  <= w_flags;
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_id    = r_id;
  assign rsp_r     = r_r;
  assign rsp_flags = r_flags;

endmodule : alu_arbiter
`default_nettype wire
